alu_matrix_sequencer: RTL and testbench
=======================================

# alu_matrix_sequencer

Initiator-side controller for the ALUMatrixTop `sel`/`eleIn`/`eleOut` element interface. It sits between a streaming host and the matrix ALU. On each accepted command it loads matrices A and B element by element, issues one operation opcode, then reads the nine result elements back and streams them out with a valid/ready handshake. It replaces hand-driven `sel` sequencing with a fixed, cycle-exact protocol engine.

## Interface

**Parameters**
- `DATA_W`, default 32: element width.
- `OP_HOLD`, default 2: cycles the operation opcode is held on `sel`. Legal range 1–15.
- `RD_LAT`, default 1: cycles from a result-select code on `sel` to a valid `eleOut`. Legal range 0–3.

**Ports** (name, direction, width, meaning)
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `cmd_valid` input 1: command request.
- `cmd_op` input 1: 0 = transpose A (code 28), 1 = A+B (code 29).
- `cmd_ready` output 1: high only in IDLE.
- `in_valid` input 1: element available.
- `in_data` input DATA_W: element. Order is A row-major, then B row-major.
- `in_ready` output 1: high only in LOAD.
- `out_valid` output 1: result element valid.
- `out_data` output DATA_W: result element, row-major.
- `out_last` output 1: marks the 9th result element.
- `out_ready` input 1: consumer accepts.
- `busy` output 1: state != IDLE.
- `sel` output 6: ALU select code, registered.
- `eleIn` output DATA_W: ALU write data, registered.
- `eleOut` input DATA_W: ALU read data.

## Operation

**ALU select codes**
- 0–8: write A[k].
- 9–17: write B[k].
- 18–26: present R[k] on `eleOut`.
- 27: NOP (idle).
- 28: transpose.
- 29: add.

**State machine: IDLE → LOAD → OP → READ → IDLE**
- **IDLE:** `sel`=27. A `cmd_valid`&`cmd_ready` handshake latches `cmd_op`, clears the element counter `k`, and moves to LOAD.
- **LOAD:** Each `in_valid`&`in_ready` beat drives `sel`=`k` and `eleIn`=`in_data` on the next cycle, then increments `k`. When no beat occurs, `sel`=27. After beat 17, go to OP.
- **OP:** `sel`=28 or 29 for exactly `OP_HOLD` cycles, then go to READ with `k`=0.
- **READ:** `sel`=18+`k` is held for `RD_LAT`+1 cycles. `eleOut` is then captured into `out_data` and `out_valid` is set. `sel` holds its value until the `out_valid`&`out_ready` handshake. After the handshake, `k` increments. The beat with `k`=8 sets `out_last`. Its handshake returns to IDLE.

**Boundary rules**
- `in_valid` outside LOAD is ignored and never dropped-then-counted.
- `cmd_valid` while busy is not accepted; the command waits.
- `out_ready` low stalls READ indefinitely. `out_data`, `out_last` and `sel` stay stable during the stall.
- Reset in any state takes effect on the next edge: return to IDLE, partial load is discarded, no output beat is emitted.
- ALU contents are not cleared by reset; the next command fully reloads them.

## Timing

**Reset values**
- `sel`=27, `eleIn`=0.
- `out_valid`=0, `out_data`=0, `out_last`=0.
- `busy`=0, `cmd_ready`=1, `in_ready`=0.

**Latency**
- Command accept at cycle c: `in_ready`=1 at c+1.
- Beat accepted at t: `sel`/`eleIn` updated at t+1.
- Last beat at t: opcode on `sel` at t+2 … t+1+`OP_HOLD`.
- First READ `sel` at t+2+`OP_HOLD`.
- First `out_valid` at t+3+`OP_HOLD`+`RD_LAT`. With defaults this is t+6.
- With `out_ready` held high, the per-element period is `RD_LAT`+2 cycles.
- `cmd_ready` returns high the cycle after the `out_last` handshake.

## Configuration

**`ALU_SEQ_SKIP_B_EN`**
- **Defined:**
  - A transpose command loads only 9 elements (A). OP is entered after beat 8.
  - Add still loads 18 elements.
  - B retains its previous contents.
- **Undefined:** every command loads 18 elements, and B beats are written during transpose too.

## Structure

- **Package `alu_matrix_pkg`:**
  - sel code constants: `SEL_A_BASE`=0, `SEL_B_BASE`=9, `SEL_R_BASE`=18, `SEL_NOP`=27, `SEL_TRANSPOSE`=28, `SEL_ADD`=29.
  - `N_ELEM`=9.
  - Op enum.
  - FSM state enum.
- **Sub-module `alu_seq_out_buf`:** single-entry output register. It holds `out_data`/`out_last`/`out_valid` and performs the handshake.
- Everything else is in the sequencer.

## Test plan

1. **Transpose:** A=0..8, B=0..8, `cmd_op`=0, `out_ready`=1 → outputs 0,3,6,1,4,7,2,5,8. `out_last` is set only on the 8. The `sel` trace is 0..17, then 28 held 2 cycles, then 18..26.
2. **Add:** same load, `cmd_op`=1 → outputs 0,2,4,…,16. First `out_valid` is 6 cycles after the last input beat.
3. **Backpressure:** `out_ready` low for 5 cycles at element 3 → `out_data` and `sel`=21 stay stable. No element is lost or duplicated.
4. **Input gaps:** `in_valid` toggled 1,0,1,0 and a `cmd_valid` pulse while busy → exactly 18 writes, with `sel`=27 in gap cycles. The second command is accepted only after `out_last`.
5. **Reset mid-LOAD:** `reset` after beat 7 → next cycle `sel`=27, `busy`=0, no output. A fresh transpose then yields the correct 9 values.
6. **`ALU_SEQ_SKIP_B_EN` defined:** transpose → `in_ready` drops after 9 beats and `sel` never takes values 9–17.

Source files
------------

// File: rtl/alu_matrix_pkg.sv
// Shared constants and types for the ALU matrix sequencer: select codes,
// element count, operation and FSM state encodings.
package alu_matrix_pkg;

    localparam int N_ELEM = 9;

    localparam logic [5:0] SEL_A_BASE    = 6'd0;
    localparam logic [5:0] SEL_B_BASE    = 6'd9;
    localparam logic [5:0] SEL_R_BASE    = 6'd18;
    localparam logic [5:0] SEL_NOP       = 6'd27;
    localparam logic [5:0] SEL_TRANSPOSE = 6'd28;
    localparam logic [5:0] SEL_ADD       = 6'd29;

    typedef enum logic {
        OP_TRANSPOSE = 1'b0,
        OP_ADD       = 1'b1
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OP   = 2'd2,
        ST_READ = 2'd3
    } seq_state_e;

    function automatic logic [5:0] op_sel_code(input alu_op_e op);
        return (op == OP_ADD) ? SEL_ADD : SEL_TRANSPOSE;
    endfunction

endpackage

// File: rtl/alu_seq_out_buf.sv
// Single-entry output register for result elements; holds data/last/valid
// stable until the consumer accepts.
module alu_seq_out_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_fire
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    assign o_fire  = r_valid & i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (o_fire) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_matrix_sequencer.sv
// Protocol engine driving the matrix ALU sel/eleIn/eleOut port: load A,B,
// issue one opcode, stream nine results. ALU_SEQ_SKIP_B_EN skips B on transpose.
import alu_matrix_pkg::*;

module alu_matrix_sequencer #(
    parameter int DATA_W  = 32,
    parameter int OP_HOLD = 2,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic              cmd_op,
    output logic              cmd_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [5:0]        sel,
    output logic [DATA_W-1:0] eleIn,
    input  logic [DATA_W-1:0] eleOut
);

    localparam logic [1:0] PH_ISSUE = 2'd0;
    localparam logic [1:0] PH_WAIT  = 2'd1;
    localparam logic [1:0] PH_HOLD  = 2'd2;

    localparam logic [3:0] OP_LAST  = 4'(OP_HOLD - 1);
    localparam logic [3:0] RD_LAST  = 4'(RD_LAT);
    localparam logic [4:0] K_LAST_A = 5'(N_ELEM - 1);
    localparam logic [4:0] K_LAST_B = 5'(2 * N_ELEM - 1);

    seq_state_e        r_state;
    alu_op_e           r_op;
    logic [4:0]        r_k;
    logic [3:0]        r_cnt;
    logic [1:0]        r_phase;
    logic [5:0]        r_sel;
    logic [DATA_W-1:0] r_ele_in;

    logic       w_cmd_fire;
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_capture;
    logic       w_res_last;
    logic [4:0] w_last_idx;

    assign cmd_ready = (r_state == ST_IDLE);
    assign in_ready  = (r_state == ST_LOAD);
    assign busy      = (r_state != ST_IDLE);
    assign sel       = r_sel;
    assign eleIn     = r_ele_in;

    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_capture  = (r_state == ST_READ) && (r_phase == PH_WAIT) && (r_cnt == RD_LAST);
    assign w_res_last = (r_k == K_LAST_A);

`ifdef ALU_SEQ_SKIP_B_EN
    // Transpose only reads A, so B keeps whatever the previous command left.
    assign w_last_idx = (r_op == OP_TRANSPOSE) ? K_LAST_A : K_LAST_B;
`else
    assign w_last_idx = K_LAST_B;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_TRANSPOSE;
            r_k      <= '0;
            r_cnt    <= '0;
            r_phase  <= PH_ISSUE;
            r_sel    <= SEL_NOP;
            r_ele_in <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sel <= SEL_NOP;
                    if (w_cmd_fire) begin
                        r_op    <= alu_op_e'(cmd_op);
                        r_k     <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_in_fire) begin
                        // A and B codes are contiguous from 0, so k is the code.
                        r_sel    <= SEL_A_BASE + {1'b0, r_k};
                        r_ele_in <= in_data;
                        r_k      <= r_k + 5'd1;
                        if (r_k == w_last_idx) begin
                            r_state <= ST_OP;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_sel <= SEL_NOP;
                    end
                end
                ST_OP: begin
                    r_sel <= op_sel_code(r_op);
                    if (r_cnt == OP_LAST) begin
                        r_state <= ST_READ;
                        r_phase <= PH_ISSUE;
                        r_k     <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_READ: begin
                    case (r_phase)
                        PH_ISSUE: begin
                            r_sel   <= SEL_R_BASE + {1'b0, r_k};
                            r_cnt   <= '0;
                            r_phase <= PH_WAIT;
                        end
                        PH_WAIT: begin
                            if (r_cnt == RD_LAST) begin
                                r_phase <= PH_HOLD;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end
                        default: begin
                            // sel stays on the current result until the beat is taken.
                            if (w_out_fire) begin
                                if (w_res_last) begin
                                    r_state <= ST_IDLE;
                                    r_sel   <= SEL_NOP;
                                end else begin
                                    r_k     <= r_k + 5'd1;
                                    r_sel   <= SEL_R_BASE + {1'b0, r_k} + 6'd1;
                                    r_cnt   <= '0;
                                    r_phase <= PH_WAIT;
                                end
                            end
                        end
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    alu_seq_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_capture),
        .i_data  (eleOut),
        .i_last  (w_res_last),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_last  (out_last),
        .o_fire  (w_out_fire)
    );

endmodule

// File: tb/tb_alu_matrix_sequencer.sv
// Bench for alu_matrix_sequencer: behavioural ALU, sel-trace monitor,
// table of commands with a result scoreboard, plus reset/stall sequences.
module tb_alu_matrix_sequencer;
    import alu_matrix_pkg::*;

    localparam int DATA_W  = 32;
    localparam int OP_HOLD = 2;
    localparam int RD_LAT  = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_op = 1'b0;
    logic              cmd_ready;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic              busy;
    logic [5:0]        sel;
    logic [DATA_W-1:0] eleIn;
    logic [DATA_W-1:0] eleOut = '0;

    alu_matrix_sequencer #(
        .DATA_W (DATA_W),
        .OP_HOLD(OP_HOLD),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_ready(cmd_ready),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy),
        .sel      (sel),
        .eleIn    (eleIn),
        .eleOut   (eleOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural matrix ALU with one cycle read latency.
    logic [DATA_W-1:0] m_a [9];
    logic [DATA_W-1:0] m_b [9];
    logic [DATA_W-1:0] m_r [9];
    always @(posedge clk) begin
        int s;
        s = int'(sel);
        if (s < 9) m_a[s] <= eleIn;
        else if (s < 18) m_b[s-9] <= eleIn;
        else if (s == 28) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) m_r[r*3+c] <= m_a[c*3+r];
        end else if (s == 29) begin
            for (int i = 0; i < 9; i++) m_r[i] <= m_a[i] + m_b[i];
        end
        eleOut <= (s >= 18 && s <= 26) ? m_r[s-18] : '0;
    end

    // sel monitor: change-point trace (NOP excluded) and per-kind cycle counts.
    int         trace_q[$];
    int         n_wr_a = 0, n_wr_b = 0, n_opc = 0;
    logic [5:0] prev_sel = SEL_NOP;
    always @(negedge clk) begin
        if (!reset) begin
            if (sel != prev_sel && sel != SEL_NOP) trace_q.push_back(int'(sel));
            if (sel < 6'd9) n_wr_a++;
            else if (sel < 6'd18) n_wr_b++;
            else if (sel == SEL_TRANSPOSE || sel == SEL_ADD) n_opc++;
        end
        prev_sel = sel;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic              last;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic              op;
        logic [DATA_W-1:0] a_mul;
        logic [DATA_W-1:0] a_add;
        logic [DATA_W-1:0] b_mul;
        logic [DATA_W-1:0] b_add;
        bit                gaps;
        int                stall_elem;
        int                stall_len;
        bit                chain;
        logic [DATA_W-1:0] exp_first;
        logic [DATA_W-1:0] exp_last;
    } vec_t;

    task automatic run_cmd(input vec_t v, input logic next_op, input bit chained_in);
        logic [DATA_W-1:0] a [9];
        logic [DATA_W-1:0] b [9];
        int nbeats, t_last, t_first, t_lasths, guard, tr0, wa0, wb0, op0, bad;
        logic [DATA_W-1:0] first_d, last_d;
        int exp_tr[$];
        for (int k = 0; k < 9; k++) begin
            a[k] = v.a_mul * 32'(k) + v.a_add;
            b[k] = v.b_mul * 32'(k) + v.b_add;
        end
        nbeats = 18;
`ifdef ALU_SEQ_SKIP_B_EN
        if (v.op == 1'b0) nbeats = 9;
`endif
        t_last = 0; t_first = -1; t_lasths = 0; first_d = '0; last_d = '0;
        tr0 = trace_q.size(); wa0 = n_wr_a; wb0 = n_wr_b; op0 = n_opc;
        $display("[TB] cmd op=%0d beats=%0d gaps=%0d stall@%0d x%0d", v.op, nbeats, v.gaps, v.stall_elem, v.stall_len);
        if (!chained_in) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = v.op;
            guard = 0;
            while (!cmd_ready && guard < 200) begin @(negedge clk); guard++; end
            chk("cmd_accept_timeout", longint'(cmd_ready), 1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("in_ready_after_accept", longint'(in_ready), 1);
        chk("busy_after_accept", longint'(busy), 1);
        fork
            begin : producer
                int k, g;
                k = 0; g = 0; guard = 0;
                while (k < nbeats && guard < 400) begin
                    if (v.gaps && g == 1) begin
                        in_valid = 1'b0;
                    end else begin
                        in_valid = 1'b1;
                        in_data = (k < 9) ? a[k] : b[k-9];
                    end
                    if (in_valid && in_ready) begin
                        if (k == nbeats - 1) begin
                            t_last = cyc;
                            for (int r = 0; r < 9; r++) begin
                                exp_t e;
                                e.data = v.op ? (a[r] + b[r]) : a[(r%3)*3 + r/3];
                                e.last = (r == 8);
                                sb_q.push_back(e);
                            end
                        end
                        k++;
                    end
                    if (v.gaps) g = 1 - g;
                    @(negedge clk);
                    guard++;
                end
                chk("load_beats", k, nbeats);
                chk("in_ready_drop", longint'(in_ready), 0);
                // Keep junk on the input while not loading: it must be ignored.
                in_valid = 1'b1;
                in_data = 32'hDEADBEEF;
                if (v.chain) begin cmd_valid = 1'b1; cmd_op = next_op; end
            end
            begin : consumer
                int n, sd, g2;
                logic [DATA_W-1:0] held;
                exp_t e;
                n = 0; sd = 0; g2 = 0; held = '0;
                out_ready = 1'b1;
                while (n < 9 && g2 < 600) begin
                    if (out_valid) begin
                        if (t_first < 0) t_first = cyc;
                        if (n == v.stall_elem && sd < v.stall_len) begin
                            if (sd == 0) held = out_data;
                            else chk("stall_data", longint'(out_data), longint'(held));
                            chk("stall_sel", longint'(sel), longint'(SEL_R_BASE) + n);
                            out_ready = 1'b0;
                            sd++;
                        end else begin
                            out_ready = 1'b1;
                            chk("sb_nonempty", longint'(sb_q.size() > 0), 1);
                            if (sb_q.size() > 0) begin
                                e = sb_q.pop_front();
                                chk("out_data", longint'(out_data), longint'(e.data));
                                chk("out_last", longint'(out_last), longint'(e.last));
                            end
                            $display("[TB] out k=%0d data=0x%0h last=%0d", n, out_data, out_last);
                            if (n == 0) first_d = out_data;
                            if (n == 8) begin
                                last_d = out_data;
                                t_lasths = cyc;
                                chk("cmd_ready_busy_read", longint'(cmd_ready), 0);
                            end
                            n++;
                        end
                    end else begin
                        out_ready = 1'b1;
                    end
                    if (n < 9) begin @(negedge clk); g2++; end
                end
                chk("out_count", n, 9);
            end
        join
        @(negedge clk);
        chk("cmd_ready_after_last", longint'(cmd_ready), 1);
        chk("cmd_ready_cycle", cyc, t_lasths + 1);
        chk("busy_after_last", longint'(busy), 0);
        chk("first_latency", t_first - t_last, OP_HOLD + RD_LAT + 3);
        chk("first_value", longint'(first_d), longint'(v.exp_first));
        chk("last_value", longint'(last_d), longint'(v.exp_last));
        chk("writes_a", n_wr_a - wa0, 9);
        chk("writes_b", n_wr_b - wb0, nbeats - 9);
        chk("op_cycles", n_opc - op0, OP_HOLD);
        for (int k = 0; k < nbeats; k++) exp_tr.push_back(k);
        exp_tr.push_back(v.op ? 29 : 28);
        for (int r = 0; r < 9; r++) exp_tr.push_back(18 + r);
        bad = (trace_q.size() - tr0 == exp_tr.size()) ? 0 : 1;
        if (bad == 0)
            for (int j = 0; j < exp_tr.size(); j++)
                if (trace_q[tr0+j] != exp_tr[j]) bad++;
        chk("sel_trace", bad, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        vec_t rv;
        int seen;
        tbl[0] = '{1'b0, 32'd1, 32'd0,   32'd1, 32'd0,          1'b0, -1, 0, 1'b0, 32'd0,  32'd8};
        tbl[1] = '{1'b1, 32'd1, 32'd0,   32'd1, 32'd0,          1'b0, -1, 0, 1'b0, 32'd0,  32'd16};
        tbl[2] = '{1'b1, 32'd3, 32'd100, 32'd1, 32'hFFFFFFF0,   1'b1,  3, 5, 1'b1, 32'h54, 32'h74};
        tbl[3] = '{1'b0, 32'd7, 32'd5,   32'd1, 32'd0,          1'b0,  0, 3, 1'b0, 32'd5,  32'd61};

        in_valid = 1'b1; in_data = 32'hBAD0BAD0;
        repeat (3) @(negedge clk);
        chk("rst_sel", longint'(sel), longint'(SEL_NOP));
        chk("rst_eleIn", longint'(eleIn), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_cmd_ready", longint'(cmd_ready), 1);
        chk("rst_in_ready", longint'(in_ready), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_in_ignored_sel", longint'(sel), longint'(SEL_NOP));
        chk("idle_in_ignored_wr", n_wr_a + n_wr_b, 0);

        for (int i = 0; i < 4; i++)
            run_cmd(tbl[i], (i < 3) ? tbl[(i+1)%4].op : 1'b0, (i > 0) ? tbl[i-1].chain : 1'b0);

        // Reset in the middle of a load: partial A discarded, no output.
        in_valid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 32'(1000 + k);
            @(negedge clk);
        end
        chk("pre_reset_sel", longint'(sel), 7);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_sel", longint'(sel), longint'(SEL_NOP));
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        chk("midrst_out_valid", longint'(out_valid), 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_output", seen, 0);
        chk("midrst_sb_empty", sb_q.size(), 0);
        rv = '{1'b0, 32'd1, 32'd50, 32'd2, 32'd0, 1'b0, -1, 0, 1'b0, 32'd50, 32'd58};
        run_cmd(rv, 1'b0, 1'b0);

        chk("final_sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
